// File: rtl/handshake_monitor.sv
// handshake_monitor
//   Runtime checker for pulse/acknowledge traffic on NUM_CH independent channels.
//   Per channel it flags over-long request pulses, request rises spaced closer
//   than MIN_INTERVAL, requests not acknowledged within MAX_LATENCY cycles and
//   acknowledges that arrive with no request outstanding.
//
// Ports
//   clk                  clock
//   rst                  synchronous active-high reset
//   enable_in            monitoring enable; when low, events are masked and
//                        per-channel trackers are parked
//   clr_in               clear all sticky status (same-cycle events still load)
//   req_in[NUM_CH]       per-channel request pulses
//   ack_in[NUM_CH]       per-channel acknowledge pulses
//   err_width_out        sticky: request held high for two or more cycles
//   err_interval_out     sticky: request rose too soon after the previous one
//   err_timeout_out      sticky: acknowledge missing within MAX_LATENCY
//   err_spurious_out     sticky: acknowledge with no outstanding request
//   err_count_out        saturating count of error events
//   first_err_valid_out  first_err_ch_out holds a captured channel
//   first_err_ch_out     lowest channel flagged in the first error cycle
//   irq_out              one-cycle pulse per cycle that registered new events

module handshake_monitor #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned MIN_INTERVAL = 16,
  parameter int unsigned MAX_LATENCY  = 8,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable_in,
  input  logic              clr_in,
  input  logic [NUM_CH-1:0] req_in,
  input  logic [NUM_CH-1:0] ack_in,
  output logic [NUM_CH-1:0] err_width_out,
  output logic [NUM_CH-1:0] err_interval_out,
  output logic [NUM_CH-1:0] err_timeout_out,
  output logic [NUM_CH-1:0] err_spurious_out,
  output logic [CNT_W-1:0]  err_count_out,
  output logic              first_err_valid_out,
  output logic [CH_W-1:0]   first_err_ch_out,
  output logic              irq_out
);

  localparam int unsigned LAT_W = $clog2(MAX_LATENCY + 1);
  localparam int unsigned IVL_W = $clog2(MIN_INTERVAL + 1);
  localparam int unsigned EV_W  = 4 * NUM_CH;
  localparam int unsigned POP_W = $clog2(EV_W + 1);
  localparam int unsigned SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;

  localparam logic [LAT_W-1:0] LatMax = LAT_W'(MAX_LATENCY);
  localparam logic [IVL_W-1:0] IvlMax = IVL_W'(MIN_INTERVAL);
  localparam logic [SUM_W-1:0] CntMax = SUM_W'({CNT_W{1'b1}});

  typedef enum logic {StIdle, StWait} state_e;

  // Request edge history
  logic [NUM_CH-1:0] req_q, req_qq, rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q  <= '0;
      req_qq <= '0;
    end else begin
      req_q  <= req_in;
      req_qq <= req_q;
    end
  end

  assign rise = req_in & ~req_q;

  // Per-channel trackers
  state_e           state_q [NUM_CH];
  logic [LAT_W-1:0] lat_q   [NUM_CH];
  logic [IVL_W-1:0] ivl_q   [NUM_CH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst || !enable_in) begin
        // Parking ivl at its ceiling makes the first rise after reset or
        // re-enable always legal.
        state_q[i] <= StIdle;
        lat_q[i]   <= '0;
        ivl_q[i]   <= IvlMax;
      end else begin
        if (rise[i]) begin
          ivl_q[i] <= IVL_W'(1);
        end else if (ivl_q[i] != IvlMax) begin
          ivl_q[i] <= ivl_q[i] + IVL_W'(1);
        end

        // A rise always (re)starts the wait; any old request is either
        // completed by a same-cycle ack or reported as a timeout.
        if (rise[i]) begin
          state_q[i] <= StWait;
          lat_q[i]   <= LAT_W'(1);
        end else if (state_q[i] == StWait) begin
          if (ack_in[i] || (lat_q[i] == LatMax)) begin
            state_q[i] <= StIdle;
            lat_q[i]   <= '0;
          end else begin
            lat_q[i] <= lat_q[i] + LAT_W'(1);
          end
        end
      end
    end
  end

  // Event detection
  logic [NUM_CH-1:0] ev_width, ev_ivl, ev_tmo, ev_spur, ch_ev;

  always_comb begin
    ev_width = '0;
    ev_ivl   = '0;
    ev_tmo   = '0;
    ev_spur  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (enable_in) begin
        ev_width[i] = req_in[i] & req_q[i] & ~req_qq[i];
        ev_ivl[i]   = rise[i] & (ivl_q[i] < IvlMax);
        if (state_q[i] == StIdle) begin
          ev_spur[i] = ack_in[i];
        end else if (!ack_in[i]) begin
          ev_tmo[i] = (lat_q[i] == LatMax) | rise[i];
        end
      end
    end
  end

  assign ch_ev = ev_width | ev_ivl | ev_tmo | ev_spur;

  logic [POP_W-1:0] pop;
  logic [CH_W-1:0]  low_ch;

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pop = pop + POP_W'(ev_width[i]) + POP_W'(ev_ivl[i])
                + POP_W'(ev_tmo[i]) + POP_W'(ev_spur[i]);
    end
  end

  always_comb begin
    low_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_ev[i]) low_ch = CH_W'(i);
    end
  end

  // Status registers
  logic [NUM_CH-1:0] width_q, width_d, ivl_err_q, ivl_err_d;
  logic [NUM_CH-1:0] tmo_q, tmo_d, spur_q, spur_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              fvalid_q, fvalid_d;
  logic [CH_W-1:0]   fch_q, fch_d;
  logic              irq_q, irq_d;
  logic [SUM_W-1:0]  sum;

  always_comb begin
    // clr_in drops the old state; this cycle's events still load.
    width_d   = (clr_in ? '0 : width_q)   | ev_width;
    ivl_err_d = (clr_in ? '0 : ivl_err_q) | ev_ivl;
    tmo_d     = (clr_in ? '0 : tmo_q)     | ev_tmo;
    spur_d    = (clr_in ? '0 : spur_q)    | ev_spur;

    sum     = (clr_in ? '0 : SUM_W'(count_q)) + SUM_W'(pop);
    count_d = (sum > CntMax) ? CntMax[CNT_W-1:0] : sum[CNT_W-1:0];

    fvalid_d = clr_in ? 1'b0 : fvalid_q;
    fch_d    = clr_in ? '0 : fch_q;
    if (!fvalid_d && (|ch_ev)) begin
      fvalid_d = 1'b1;
      fch_d    = low_ch;
    end

    irq_d = |ch_ev;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      width_q   <= '0;
      ivl_err_q <= '0;
      tmo_q     <= '0;
      spur_q    <= '0;
      count_q   <= '0;
      fvalid_q  <= 1'b0;
      fch_q     <= '0;
      irq_q     <= 1'b0;
    end else begin
      width_q   <= width_d;
      ivl_err_q <= ivl_err_d;
      tmo_q     <= tmo_d;
      spur_q    <= spur_d;
      count_q   <= count_d;
      fvalid_q  <= fvalid_d;
      fch_q     <= fch_d;
      irq_q     <= irq_d;
    end
  end

  assign err_width_out       = width_q;
  assign err_interval_out    = ivl_err_q;
  assign err_timeout_out     = tmo_q;
  assign err_spurious_out    = spur_q;
  assign err_count_out       = count_q;
  assign first_err_valid_out = fvalid_q;
  assign first_err_ch_out    = fch_q;
  assign irq_out             = irq_q;

endmodule

// File: tb/tb_handshake_monitor.sv
// Directed bench for handshake_monitor (NUM_CH=4, MIN_INTERVAL=16, MAX_LATENCY=8).
// A second instance with CNT_W=2 shares the stimulus for counter saturation.

module tb_handshake_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable_in = 1'b1;
  logic       clr_in = 1'b0;
  logic [3:0] req_in = '0;
  logic [3:0] ack_in = '0;

  logic [3:0] err_width_out, err_interval_out, err_timeout_out, err_spurious_out;
  logic [7:0] err_count_out;
  logic       first_err_valid_out;
  logic [1:0] first_err_ch_out;
  logic       irq_out;

  logic [3:0] w2, i2, t2, s2;
  logic [1:0] cnt2;
  logic       v2;
  logic [1:0] ch2;
  logic       irq2;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned irq_hits = 0;

  always #5 clk = ~clk;

  handshake_monitor #(
    .NUM_CH(4), .MIN_INTERVAL(16), .MAX_LATENCY(8), .CNT_W(8)
  ) u_dut (
    .clk                (clk),
    .rst                (rst),
    .enable_in          (enable_in),
    .clr_in             (clr_in),
    .req_in             (req_in),
    .ack_in             (ack_in),
    .err_width_out      (err_width_out),
    .err_interval_out   (err_interval_out),
    .err_timeout_out    (err_timeout_out),
    .err_spurious_out   (err_spurious_out),
    .err_count_out      (err_count_out),
    .first_err_valid_out(first_err_valid_out),
    .first_err_ch_out   (first_err_ch_out),
    .irq_out            (irq_out)
  );

  handshake_monitor #(
    .NUM_CH(4), .MIN_INTERVAL(16), .MAX_LATENCY(8), .CNT_W(2)
  ) u_dut2 (
    .clk                (clk),
    .rst                (rst),
    .enable_in          (enable_in),
    .clr_in             (clr_in),
    .req_in             (req_in),
    .ack_in             (ack_in),
    .err_width_out      (w2),
    .err_interval_out   (i2),
    .err_timeout_out    (t2),
    .err_spurious_out   (s2),
    .err_count_out      (cnt2),
    .first_err_valid_out(v2),
    .first_err_ch_out   (ch2),
    .irq_out            (irq2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] w, input logic [3:0] iv,
                           input logic [3:0] t, input logic [3:0] s, input int unsigned cnt,
                           input logic v, input logic [1:0] ch, input logic irq);
    check({tag, " width"},    32'(err_width_out),       32'(w));
    check({tag, " interval"}, 32'(err_interval_out),    32'(iv));
    check({tag, " timeout"},  32'(err_timeout_out),     32'(t));
    check({tag, " spurious"}, 32'(err_spurious_out),    32'(s));
    check({tag, " count"},    32'(err_count_out),       cnt);
    check({tag, " fvalid"},   32'(first_err_valid_out), 32'(v));
    check({tag, " fch"},      32'(first_err_ch_out),    32'(ch));
    check({tag, " irq"},      32'(irq_out),             32'(irq));
  endtask

  // Outputs are sampled 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (irq_out) irq_hits++;
  endtask

  task automatic cyc(input logic [3:0] r, input logic [3:0] a);
    req_in = r;
    ack_in = a;
    tick();
    req_in = '0;
    ack_in = '0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(4'b0000, 4'b0000);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_in = '0;
    ack_in = '0;
    clr_in = 1'b0;
    enable_in = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    irq_hits = 0;
  endtask

  initial begin
    // Reset state
    do_reset();
    check_all("reset", 4'h0, 4'h0, 4'h0, 4'h0, 0, 1'b0, 2'd0, 1'b0);
    check("reset cnt2", 32'(cnt2), 32'd0);

    // Ch2 request acknowledged at the latest legal cycle
    idle(10);
    cyc(4'b0100, 4'b0000);
    idle(7);
    cyc(4'b0000, 4'b0100);
    idle(2);
    check_all("ack_ok", 4'h0, 4'h0, 4'h0, 4'h0, 0, 1'b0, 2'd0, 1'b0);
    check("ack_ok irq_hits", irq_hits, 0);

    // Ch1 timeout
    do_reset();
    cyc(4'b0010, 4'b0000);
    idle(7);
    check("tmo_early", 32'(err_timeout_out), 32'h0);
    cyc(4'b0000, 4'b0000);
    check_all("tmo", 4'h0, 4'h0, 4'b0010, 4'h0, 1, 1'b1, 2'd1, 1'b1);
    cyc(4'b0000, 4'b0000);
    check("tmo irq_drop", 32'(irq_out), 32'd0);
    check("tmo sticky", 32'(err_timeout_out), 32'b0010);

    // Ch1 re-request before ack: timeout for the abandoned one plus interval
    do_reset();
    cyc(4'b0010, 4'b0000);
    idle(3);
    cyc(4'b0010, 4'b0000);
    check_all("abandon", 4'h0, 4'b0010, 4'b0010, 4'h0, 2, 1'b1, 2'd1, 1'b1);
    cyc(4'b0000, 4'b0010);
    check("abandon ack cnt", 32'(err_count_out), 32'd2);
    check("abandon ack irq", 32'(irq_out), 32'd0);

    // Ch0 width error, then ch3 interval boundary
    do_reset();
    cyc(4'b0001, 4'b0000);
    check("width_first", 32'(err_width_out), 32'h0);
    cyc(4'b0001, 4'b0001);
    check_all("width", 4'b0001, 4'h0, 4'h0, 4'h0, 1, 1'b1, 2'd0, 1'b1);
    cyc(4'b0001, 4'b0000);
    check("width_once cnt", 32'(err_count_out), 32'd1);
    check("width_once irq", 32'(irq_out), 32'd0);
    idle(1);
    cyc(4'b1000, 4'b0000);
    cyc(4'b0000, 4'b1000);
    idle(14);
    cyc(4'b1000, 4'b0000);       // exactly MIN_INTERVAL later: legal
    check("ivl_legal", 32'(err_interval_out), 32'h0);
    cyc(4'b0000, 4'b1000);
    idle(13);
    cyc(4'b1000, 4'b0000);       // MIN_INTERVAL-1 later: error
    check_all("ivl", 4'b0001, 4'b1000, 4'h0, 4'h0, 2, 1'b1, 2'd0, 1'b1);

    // Spurious acks, including ack in the rise cycle
    do_reset();
    cyc(4'b0000, 4'b1001);
    check_all("spur", 4'h0, 4'h0, 4'h0, 4'b1001, 2, 1'b1, 2'd0, 1'b1);
    cyc(4'b0100, 4'b0100);
    cyc(4'b0000, 4'b0100);
    check_all("spur_rise", 4'h0, 4'h0, 4'h0, 4'b1101, 3, 1'b1, 2'd0, 1'b0);

    // Saturation on the CNT_W=2 instance, then clear with a same-cycle event
    do_reset();
    cyc(4'b0000, 4'b0011);
    check("sat cnt2 a", 32'(cnt2), 32'd2);
    check("sat irq a", 32'(irq2), 32'd1);
    cyc(4'b0000, 4'b0111);
    check("sat cnt2 b", 32'(cnt2), 32'd3);
    check("sat irq b", 32'(irq2), 32'd1);
    check("sat cnt8", 32'(err_count_out), 32'd5);
    cyc(4'b0000, 4'b0000);
    check("sat irq c", 32'(irq2), 32'd0);
    cyc(4'b0100, 4'b0000);
    clr_in = 1'b1;
    cyc(4'b0100, 4'b0100);
    clr_in = 1'b0;
    check("clr w2", 32'(w2), 32'b0100);
    check("clr s2", 32'(s2), 32'h0);
    check("clr cnt2", 32'(cnt2), 32'd1);
    check("clr v2", 32'(v2), 32'd1);
    check("clr ch2", 32'(ch2), 32'd2);
    check("clr irq2", 32'(irq2), 32'd1);
    check_all("clr", 4'b0100, 4'h0, 4'h0, 4'h0, 1, 1'b1, 2'd2, 1'b1);
    clr_in = 1'b1;
    cyc(4'b0000, 4'b0000);
    clr_in = 1'b0;
    check_all("clr_only", 4'h0, 4'h0, 4'h0, 4'h0, 0, 1'b0, 2'd0, 1'b0);

    // Disabled monitoring: masked events, parked trackers
    do_reset();
    enable_in = 1'b0;
    idle(10);
    cyc(4'b0001, 4'b0000);       // t=10
    idle(1);
    cyc(4'b0000, 4'b0001);       // masked spurious
    idle(2);
    cyc(4'b0001, 4'b0000);       // t=15
    enable_in = 1'b1;
    idle(4);
    cyc(4'b0001, 4'b0000);       // t=20
    cyc(4'b0000, 4'b0000);
    cyc(4'b0000, 4'b0001);       // t=22
    idle(12);
    check_all("enable", 4'h0, 4'h0, 4'h0, 4'h0, 0, 1'b0, 2'd0, 1'b0);
    check("enable irq_hits", irq_hits, 0);

    // Reset mid-wait discards the request; a rise during reset is ignored
    do_reset();
    cyc(4'b0010, 4'b0000);
    idle(3);
    rst = 1'b1;
    req_in = 4'b0010;
    tick();
    rst = 1'b0;
    req_in = '0;
    irq_hits = 0;
    idle(12);
    check_all("rst_wait", 4'h0, 4'h0, 4'h0, 4'h0, 0, 1'b0, 2'd0, 1'b0);
    check("rst_wait irq_hits", irq_hits, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
